// File: rtl/free_list_ctrl.sv
// free_list_ctrl: circular-buffer manager for the physical-register free list.
// Dispatch pops up to N registers per cycle from the head, retire pushes up to
// N freed registers per cycle at the tail, and a mispredict rewinds the head
// to a checkpoint taken by the branch stack.
//
// Optional build macro FREE_LIST_CHECK_EN adds a sticky 'error' output, clamps
// illegal pops/pushes and enables assertions on the legal-use contract.
module free_list_ctrl #(
    parameter int N               = 3,
    parameter int PHYS_REGS       = 64,
    parameter int ARCH_REGS       = 32,
    parameter int DEPTH           = PHYS_REGS - ARCH_REGS,
    parameter int PTR_W           = $clog2(DEPTH) + 1,
    parameter int NUM_SCALAR_BITS = $clog2(N + 1),
    parameter int PHYS_REG_IDX    = $clog2(PHYS_REGS),
    parameter int COUNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_SCALAR_BITS-1:0]          num_allocating,
    output logic [N-1:0][PHYS_REG_IDX-1:0]      allocated_regs,
    output logic [COUNT_W-1:0]                  free_count,
    input  logic [NUM_SCALAR_BITS-1:0]          num_freeing,
    input  logic [N-1:0][PHYS_REG_IDX-1:0]      freed_regs,
    output logic [PTR_W-1:0]                    head_ptr,
    input  logic                                mispredict,
    input  logic [PTR_W-1:0]                    restore_head_ptr
`ifdef FREE_LIST_CHECK_EN
    ,
    output logic                                error
`endif
);

    // Buffer index width; the pointer carries one extra wrap bit above it.
    localparam int IDX_W = PTR_W - 1;

    logic [PHYS_REG_IDX-1:0]    fl_buf [DEPTH];
    logic [PTR_W-1:0]           head;
    logic [PTR_W-1:0]           tail;
    logic [PTR_W-1:0]           count;
    logic [PTR_W-1:0]           head_next;
    logic [PTR_W-1:0]           tail_next;
    logic [NUM_SCALAR_BITS-1:0] pop_amt;
    logic [NUM_SCALAR_BITS-1:0] push_amt;
    logic [IDX_W-1:0]           wr_idx [N];

`ifdef FREE_LIST_CHECK_EN
    logic [PTR_W-1:0] room;
    logic             alloc_over;
    logic             push_over;
`endif

    // Wrap bit makes full (tail-head == DEPTH) distinct from empty (== 0).
    assign count      = tail - head;
    assign free_count = COUNT_W'(count);
    assign head_ptr   = head;

    // Read lanes straight from the buffer; pushes land only at the edge, so no bypass.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            allocated_regs[i] = fl_buf[head[IDX_W-1:0] + IDX_W'(i)];
        end
    end

    // Next-pointer computation: mispredict overrides the pop, pushes always apply.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves
        // it unassigned; an unassigned path would infer a latch.
        pop_amt  = num_allocating;
        push_amt = num_freeing;
`ifdef FREE_LIST_CHECK_EN
        alloc_over = 1'b0;
        push_over  = 1'b0;
        if (!mispredict && (PTR_W'(num_allocating) > count)) begin
            alloc_over = 1'b1;
            pop_amt    = NUM_SCALAR_BITS'(count);
        end
`endif
        head_next = mispredict ? restore_head_ptr : head + PTR_W'(pop_amt);
`ifdef FREE_LIST_CHECK_EN
        // Space left once the head has moved; excess retire lanes are dropped.
        room = PTR_W'(DEPTH) - (tail - head_next);
        if (PTR_W'(num_freeing) > room) begin
            push_over = 1'b1;
            push_amt  = NUM_SCALAR_BITS'(room);
        end
`endif
        tail_next = tail + PTR_W'(push_amt);
        for (int i = 0; i < N; i++) begin
            wr_idx[i] = tail[IDX_W-1:0] + IDX_W'(i);
        end
    end

    // Buffer and pointer state; reset restores the full initial free list.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: this buffer is reset on purpose: after reset it must hold the
            // registers ARCH_REGS..PHYS_REGS-1, so it cannot be left uninitialised.
            for (int i = 0; i < DEPTH; i++) begin
                fl_buf[i] <= PHYS_REG_IDX'(ARCH_REGS + i);
            end
            head <= '0;
            tail <= PTR_W'(DEPTH);
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i < int'(push_amt)) begin
                    fl_buf[wr_idx[i]] <= freed_regs[i];
                end
            end
            head <= head_next;
            tail <= tail_next;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    // Sticky contract-violation flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            error <= 1'b0;
        end else if (alloc_over || push_over) begin
            error <= 1'b1;
        end
    end

    a_alloc_within_count: assert property (@(posedge clock) disable iff (reset) !alloc_over);
    a_push_within_depth:  assert property (@(posedge clock) disable iff (reset) !push_over);
`endif

endmodule
